seg7_frame_receiver: RTL and testbench
======================================

# seg7_frame_receiver

Serial-to-parallel receiver for the 3-wire 74HC595 display bus (shift clock, serial data, latch clock) driven by the spectrum display driver. It oversamples the bus on the system clock, rebuilds each 16-bit frame (active-low digit select byte plus 7-segment code byte) and decodes it back to a digit index and a 4-bit value. It keeps an 8-digit shadow of the display image for on-chip loopback checking and readback. Malformed frames are flagged.

## Interface
- SYNC_STAGES, 2: synchronizer depth on each bus input (≥2).
- FRAME_BITS, 16: bits per frame, MSB first.
- TIMEOUT, 4095: idle clk cycles after which a partial frame is discarded.
- clk  in  1  system clock; must be at least the transmitter clock frequency.
- rst_n  in  1  asynchronous, active-low reset.
- seg_sck_in  in  1  shift clock from the bus (asynchronous).
- seg_din_in  in  1  serial data from the bus (asynchronous).
- seg_rck_in  in  1  latch clock from the bus (asynchronous).
- digit_values  out  32  shadow image; digit d at [4d+3:4d].
- frame_valid  out  1  one-cycle pulse: a good frame was decoded.
- frame_digit  out  3  digit index of the last good frame.
- frame_value  out  4  value of the last good frame.
- scan_done  out  1  one-cycle pulse with a good frame_valid where frame_digit==7.
- err_length  out  1  one-cycle pulse: bit count ≠ FRAME_BITS at latch, or timeout.
- err_select  out  1  one-cycle pulse: select byte not exactly one zero bit.
- err_segcode  out  1  one-cycle pulse: segment byte not one of the 16 codes.

## Operation
- Each bus input passes through a SYNC_STAGES flip-flop chain. A rise is sync_out & ~sync_out_prev.
- sck rise: sr <= {sr[FRAME_BITS-2:0], din_sync}. bit_cnt increments and saturates at 31. din is sampled in the same cycle as the sck rise, because the transmitter changes din together with the sck rise.
- FSM states:
  - IDLE (bit_cnt==0): first sck rise → SHIFT.
  - SHIFT: rck rise → DECODE. TIMEOUT cycles with no sck rise → clear bit_cnt, pulse err_length, → IDLE.
  - DECODE (1 cycle): evaluate the captured word, clear bit_cnt, → IDLE.
- rck rise in IDLE (bit_cnt==0): err_length pulses; nothing is stored.
- Capture at rck rise: word <= sr (including any bit shifted in the same cycle), cnt_at_latch <= bit_cnt.
- Decode rules:
  - cnt_at_latch ≠ FRAME_BITS → err_length only; no store.
  - Else if word[15:8] is not ~(1<<d) for some d in 0..7 → err_select; no store.
  - Else if word[7:0] is not in {3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71} → err_segcode; no store.
  - Else store value v (0..15) into digit d, set frame_digit=d and frame_value=v, pulse frame_valid. Pulse scan_done if d==7.
- When a frame has both a select error and a segment-code error, only err_select pulses. Error pulses are mutually exclusive.
- Reset mid-frame: all state clears; the next frame is received from bit 0.

## Timing
- Reset values: digit_values=0, frame_digit=0, frame_value=0; all pulses 0; FSM=IDLE; sr=0; bit_cnt=0.
- Let edge k be the first clk edge that samples seg_rck_in high. frame_valid (or the error pulse) is high for exactly one cycle after edge k+SYNC_STAGES+1. digit_values updates on that same edge.
- Minimum sck high, sck low and rck high: 1 cycle of clk each.
- sck rises arriving during DECODE are accepted as bit 1 of the next frame.
- The timeout counter resets on every sck rise and every rck rise. It counts only in SHIFT.

## Structure
- The shared package seg7_pkg holds:
  - the 16 segment codes, also used by the display driver;
  - the FRAME_BITS default;
  - the FSM state enum.
- Sub-module seg7_input_sync: SYNC_STAGES synchronizer plus rise detector, instantiated three times.
- The segment-code-to-value decode is a package function.

## Test plan
- Send 0xFB6D MSB first (digit 2, code 6D), then rck → frame_valid, frame_digit=2, frame_value=5, digit_values[11:8]=5; no error pulse.
- Send a full scan of 8 frames for digits 0..7 with values 1..8 → digit_values=0x87654321; scan_done pulses once, on the digit-7 frame.
- Send 15 bits, then rck → err_length pulses; digit_values unchanged. Send 17 bits, then rck → err_length pulses.
- Send 0xF36D (two select bits low) → err_select only. Send 0xFE00 → err_segcode only. Neither stores a value.
- Send 8 bits, then idle TIMEOUT+1 cycles → err_length pulses; FSM returns to IDLE. A following good frame 0x7F71 → digit 7, value 15, scan_done pulses.
- Assert rst_n low after 9 bits of a frame → all outputs return to reset values. A complete frame 0xFE3F after release → digit 0, value 0, frame_valid pulses.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, frame size and receiver FSM states shared by the seg7 display blocks.
package seg7_pkg;

    localparam int FRAME_BITS_DEF = 16;

    // Index i holds the segment code that displays hex value i
    localparam logic [15:0][7:0] SEG_CODES = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} rx_state_t;

    // Returns {hit, value}; hit is 0 when the code is not one of the 16 glyphs
    function automatic logic [4:0] seg_decode(input logic [7:0] code);
        seg_decode = 5'd0;
        for (int i = 0; i < 16; i++)
            if (code == SEG_CODES[i]) seg_decode = {1'b1, 4'(i)};
    endfunction

endpackage

// File: rtl/seg7_input_sync.sv
// seg7_input_sync: multi-stage synchronizer for one bus wire plus a rising-edge detector.
module seg7_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev;

endmodule

// File: rtl/seg7_frame_receiver.sv
// seg7_frame_receiver: rebuilds 74HC595 display frames from the 3-wire bus and keeps a shadow of the digits.
module seg7_frame_receiver
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int TIMEOUT     = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_sck_in,
    input  logic        seg_din_in,
    input  logic        seg_rck_in,
    output logic [31:0] digit_values,
    output logic        frame_valid,
    output logic [2:0]  frame_digit,
    output logic [3:0]  frame_value,
    output logic        scan_done,
    output logic        err_length,
    output logic        err_select,
    output logic        err_segcode
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic sck_rise, rck_rise, din_sync, din_rise_unused, sck_level_unused, rck_level_unused;
    rx_state_t state, state_next;
    logic [FRAME_BITS-1:0] sr, sr_next, word;
    logic [4:0] bit_cnt, cnt_inc, cnt_at_latch, seg;
    logic [TW-1:0] tmo_cnt;
    logic [7:0] sel;
    logic [2:0] sel_digit;
    logic sel_ok, len_ok, timeout, dec, good;

    seg7_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst_n(rst_n), .async_in(seg_sck_in), .sync_out(sck_level_unused), .rise(sck_rise));
    seg7_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_din (
        .clk(clk), .rst_n(rst_n), .async_in(seg_din_in), .sync_out(din_sync), .rise(din_rise_unused));
    seg7_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rck (
        .clk(clk), .rst_n(rst_n), .async_in(seg_rck_in), .sync_out(rck_level_unused), .rise(rck_rise));

    // din and sck share the same synchronizer depth, so din_sync is the bit launched with this sck edge
    assign sr_next = sck_rise ? {sr[FRAME_BITS-2:0], din_sync} : sr;
    assign cnt_inc = (sck_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
    assign timeout = state == SHIFT && !sck_rise && !rck_rise && tmo_cnt == TW'(TIMEOUT - 1);

    assign sel    = word[FRAME_BITS-1 -: 8];
    assign seg    = seg_decode(word[7:0]);
    assign len_ok = cnt_at_latch == 5'(FRAME_BITS);
    assign dec    = state == DECODE;
    assign good   = dec && len_ok && sel_ok && seg[4];

    always_comb begin
        sel_ok    = 1'b0;
        sel_digit = 3'd0;
        for (int d = 0; d < 8; d++)
            if (sel == ~(8'd1 << d)) begin
                sel_ok    = 1'b1;
                sel_digit = 3'(d);
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = sck_rise ? SHIFT : IDLE;
            SHIFT:   state_next = rck_rise ? DECODE : timeout ? IDLE : SHIFT;
            DECODE:  state_next = sck_rise ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            word         <= '0;
            bit_cnt      <= '0;
            cnt_at_latch <= '0;
            tmo_cnt      <= '0;
            digit_values <= '0;
            frame_digit  <= '0;
            frame_value  <= '0;
            frame_valid  <= 1'b0;
            scan_done    <= 1'b0;
            err_length   <= 1'b0;
            err_select   <= 1'b0;
            err_segcode  <= 1'b0;
        end else begin
            sr      <= sr_next;
            bit_cnt <= dec ? {4'd0, sck_rise} : timeout ? 5'd0 : cnt_inc;
            tmo_cnt <= (state != SHIFT || sck_rise || rck_rise || timeout) ? '0 : tmo_cnt + 1'b1;
            if (state == SHIFT && rck_rise) begin
                word         <= sr_next;
                cnt_at_latch <= cnt_inc;
            end
            err_length  <= (state == IDLE && rck_rise) || timeout || (dec && !len_ok);
            err_select  <= dec && len_ok && !sel_ok;
            err_segcode <= dec && len_ok && sel_ok && !seg[4];
            frame_valid <= good;
            scan_done   <= good && sel_digit == 3'd7;
            if (good) begin
                frame_digit <= sel_digit;
                frame_value <= seg[3:0];
                digit_values[{sel_digit, 2'b00} +: 4] <= seg[3:0];
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_receiver.sv
// tb_seg7_frame_receiver: directed frame vectors plus timeout, idle-latch and mid-frame reset sequences.
module tb_seg7_frame_receiver;

    localparam int TIMEOUT = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0, din = 1'b0, rck = 1'b0;
    logic [31:0] digit_values;
    logic        frame_valid, scan_done, err_length, err_select, err_segcode;
    logic [2:0]  frame_digit;
    logic [3:0]  frame_value;

    int tests = 0, fails = 0;
    int n_valid, n_len, n_sel, n_seg, n_scan, lat;

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          v, l, s, g, sc;
        logic [31:0] dv;
        logic [2:0]  fd;
        logic [3:0]  fv;
    } vec_t;

    vec_t vecs[14];

    seg7_frame_receiver #(.SYNC_STAGES(2), .FRAME_BITS(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .seg_sck_in(sck), .seg_din_in(din), .seg_rck_in(rck),
        .digit_values(digit_values), .frame_valid(frame_valid), .frame_digit(frame_digit),
        .frame_value(frame_value), .scan_done(scan_done), .err_length(err_length),
        .err_select(err_select), .err_segcode(err_segcode));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        sck = 1'b1;
        repeat (2) @(negedge clk);
        sck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    // Counts pulse cycles for n clocks; lat is the first sample index showing any pulse
    task automatic watch(input int n);
        n_valid = 0; n_len = 0; n_sel = 0; n_seg = 0; n_scan = 0; lat = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            n_valid += int'(frame_valid);
            n_len   += int'(err_length);
            n_sel   += int'(err_select);
            n_seg   += int'(err_segcode);
            n_scan  += int'(scan_done);
            if (lat == 0 && (frame_valid | err_length | err_select | err_segcode)) lat = i;
            if (i == 2) rck = 1'b0;
        end
    endtask

    task automatic latch();
        rck = 1'b1;
        watch(10);
    endtask

    task automatic check_pulses(input string tag, input int v, input int l, input int s, input int g, input int sc);
        check({tag, " frame_valid"}, n_valid, v);
        check({tag, " err_length"}, n_len, l);
        check({tag, " err_select"}, n_sel, s);
        check({tag, " err_segcode"}, n_seg, g);
        check({tag, " scan_done"}, n_scan, sc);
    endtask

    initial begin
        vecs[0]  = '{32'hFB6D,  16, 1, 0, 0, 0, 0, 32'h00000500, 3'd2, 4'd5};
        vecs[1]  = '{32'hFE06,  16, 1, 0, 0, 0, 0, 32'h00000501, 3'd0, 4'd1};
        vecs[2]  = '{32'hFD5B,  16, 1, 0, 0, 0, 0, 32'h00000521, 3'd1, 4'd2};
        vecs[3]  = '{32'hFB4F,  16, 1, 0, 0, 0, 0, 32'h00000321, 3'd2, 4'd3};
        vecs[4]  = '{32'hF766,  16, 1, 0, 0, 0, 0, 32'h00004321, 3'd3, 4'd4};
        vecs[5]  = '{32'hEF6D,  16, 1, 0, 0, 0, 0, 32'h00054321, 3'd4, 4'd5};
        vecs[6]  = '{32'hDF7D,  16, 1, 0, 0, 0, 0, 32'h00654321, 3'd5, 4'd6};
        vecs[7]  = '{32'hBF07,  16, 1, 0, 0, 0, 0, 32'h07654321, 3'd6, 4'd7};
        vecs[8]  = '{32'h7F7F,  16, 1, 0, 0, 0, 1, 32'h87654321, 3'd7, 4'd8};
        vecs[9]  = '{32'h7B6D,  15, 0, 1, 0, 0, 0, 32'h87654321, 3'd7, 4'd8};
        vecs[10] = '{32'h1FB6D, 17, 0, 1, 0, 0, 0, 32'h87654321, 3'd7, 4'd8};
        vecs[11] = '{32'hF36D,  16, 0, 0, 1, 0, 0, 32'h87654321, 3'd7, 4'd8};
        vecs[12] = '{32'hFE00,  16, 0, 0, 0, 1, 0, 32'h87654321, 3'd7, 4'd8};
        vecs[13] = '{32'h0000,  16, 0, 0, 1, 0, 0, 32'h87654321, 3'd7, 4'd8};

        repeat (3) @(negedge clk);
        check("reset digit_values", digit_values, 32'h0);
        check("reset frame_digit", 32'(frame_digit), 32'h0);
        check("reset pulses", {frame_valid, scan_done, err_length, err_select, err_segcode}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            send(vecs[k].bits, vecs[k].n);
            latch();
            check_pulses(tag, vecs[k].v, vecs[k].l, vecs[k].s, vecs[k].g, vecs[k].sc);
            check({tag, " latency"}, lat, 4);
            check({tag, " digit_values"}, digit_values, vecs[k].dv);
            check({tag, " frame_digit"}, 32'(frame_digit), 32'(vecs[k].fd));
            check({tag, " frame_value"}, 32'(frame_value), 32'(vecs[k].fv));
        end

        send(32'hA5, 8);
        watch(TIMEOUT + 20);
        check_pulses("timeout", 0, 1, 0, 0, 0);
        send(32'h7F71, 16);
        latch();
        check_pulses("after_timeout", 1, 0, 0, 0, 1);
        check("after_timeout frame_digit", 32'(frame_digit), 32'd7);
        check("after_timeout frame_value", 32'(frame_value), 32'd15);
        check("after_timeout digit_values", digit_values, 32'hF7654321);

        latch();
        check_pulses("idle_latch", 0, 1, 0, 0, 0);
        check("idle_latch digit_values", digit_values, 32'hF7654321);

        send(32'h1FF, 9);
        rst_n = 1'b0;
        #1;
        check("midreset digit_values", digit_values, 32'h0);
        check("midreset frame_digit", 32'(frame_digit), 32'h0);
        check("midreset frame_value", 32'(frame_value), 32'h0);
        check("midreset pulses", {frame_valid, scan_done, err_length, err_select, err_segcode}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(32'hFE3F, 16);
        latch();
        check_pulses("post_reset", 1, 0, 0, 0, 0);
        check("post_reset frame_digit", 32'(frame_digit), 32'd0);
        check("post_reset frame_value", 32'(frame_value), 32'd0);
        check("post_reset digit_values", digit_values, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
